// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge conditioning stage.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } deb_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser for a single asynchronous bit; resets to 0.
module sync_2ff
  import debounce_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain every clock, independent of any qualifier.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/debounce_edge.sv
// Debounces a raw level into a clean registered level plus one-cycle rise/fall pulses.
// Build option: define DEBOUNCE_SYNC_EN to put a 2-FF synchroniser in front of the FSM
// (adds two cycles of latency); leave it undefined when i_raw is already synchronous.
//
// state     | meaning
// IDLE_LOW  | accepted level 0, input agrees
// WAIT_HIGH | accepted level 0, counting consecutive 1 samples
// IDLE_HIGH | accepted level 1, input agrees
// WAIT_LOW  | accepted level 1, counting consecutive 0 samples
module debounce_edge
  import debounce_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic i_sync_reset,
  input  logic i_sample_en,
  input  logic i_raw,
  output logic o_value,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s_in;
  deb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             value_q;
  logic             rise_q;
  logic             fall_q;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (async_reset_n),
    .d_i    (i_raw),
    .q_o    (s_in)
  );
`else
  assign s_in = i_raw;
`endif

  // FSM, run-length counter and registered level/pulse outputs; pulses self-clear every edge.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      value_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else if (i_sync_reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      value_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (i_sample_en) begin
        unique case (state_q)
          IDLE_LOW: begin
            if (s_in) begin
              state_q <= WAIT_HIGH;
              cnt_q   <= CNT_ONE;
            end
          end
          WAIT_HIGH: begin
            if (!s_in) begin
              state_q <= IDLE_LOW;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE_HIGH;
              cnt_q   <= '0;
              value_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!s_in) begin
              state_q <= WAIT_LOW;
              cnt_q   <= CNT_ONE;
            end
          end
          WAIT_LOW: begin
            if (s_in) begin
              state_q <= IDLE_HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE_LOW;
              cnt_q   <= '0;
              value_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            value_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_value = value_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule : debounce_edge

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: expected pulses (kind and edge number) are queued
// when stimulus is applied and matched against the pulses the DUT emits.
module tb_debounce_edge;

  localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic        kind;   // 1 = rise, 0 = fall
    int unsigned at;     // edge count at which the pulse must be visible
  } exp_t;

  logic clk = 1'b0;
  logic async_reset_n;
  logic i_sync_reset;
  logic i_sample_en;
  logic i_raw;
  logic o_value;
  logic o_rise;
  logic o_fall;

  int unsigned ecnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  exp_t        exp_q[$];

  debounce_edge #(.DEBOUNCE_CYCLES(N)) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .i_sync_reset  (i_sync_reset),
    .i_sample_en   (i_sample_en),
    .i_raw         (i_raw),
    .o_value       (o_value),
    .o_rise        (o_rise),
    .o_fall        (o_fall)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp expected and observed pulses.
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  task automatic push_exp(input logic kind, input int unsigned at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_q(input string tag);
    check_eq({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Pulse monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (async_reset_n && (o_rise || o_fall)) begin
      check_eq("pulse_excl", {31'd0, o_rise & o_fall}, 0);
      if (exp_q.size() == 0) begin
        check_eq("unexp_pulse", {30'd0, o_rise, o_fall}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("pulse_kind", {31'd0, o_rise}, {31'd0, e.kind});
        check_eq("pulse_edge", ecnt, e.at);
        check_eq("pulse_value", {31'd0, o_value}, {31'd0, e.kind});
      end
    end
  end

  // Alternating-enable run: enable held during sync latency, then 1/0/1/0 per edge.
  task automatic gated(input logic val, input string tag);
    int unsigned e0;
    int          en_cnt;
    e0     = ecnt;
    en_cnt = 0;
    i_raw  = val;
    for (int k = 1; k <= 2 * N + LAT + 4; k++) begin
      i_sample_en = (k <= LAT) ? 1'b1 : (((k - LAT) % 2) == 1);
      if (i_sample_en && k > LAT) begin
        en_cnt++;
        if (en_cnt == N) push_exp(val, e0 + k);
      end
      @(negedge clk);
    end
    i_sample_en = 1'b1;
    idle(4);
    check_q(tag);
    check_eq({tag, "_value"}, {31'd0, o_value}, {31'd0, val});
  endtask

  initial begin
    int unsigned e0;
    async_reset_n = 1'b0;
    i_sync_reset  = 1'b0;
    i_sample_en   = 1'b1;
    i_raw         = 1'b1;

    // Reset held with raw high: all outputs low.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_value", {31'd0, o_value}, 0);
      check_eq("rst_pulse", {30'd0, o_rise, o_fall}, 0);
    end
    async_reset_n = 1'b1;
    i_raw         = 1'b0;
    idle(8);
    check_q("rst_release");
    check_eq("rst_release_value", {31'd0, o_value}, 0);

    // Clean rise and clean fall.
    i_raw = 1'b1;
    push_exp(1'b1, ecnt + N + LAT);
    idle(10);
    check_q("rise");
    check_eq("rise_value", {31'd0, o_value}, 1);
    i_raw = 1'b0;
    push_exp(1'b0, ecnt + N + LAT);
    idle(10);
    check_q("fall");
    check_eq("fall_value", {31'd0, o_value}, 0);

    // N-1 samples rejected, N samples accepted.
    i_raw = 1'b1;
    idle(N - 1);
    i_raw = 1'b0;
    idle(10);
    check_q("glitch_short");
    check_eq("glitch_short_value", {31'd0, o_value}, 0);
    i_raw = 1'b1;
    push_exp(1'b1, ecnt + N + LAT);
    idle(N);
    i_raw = 1'b0;
    push_exp(1'b0, ecnt + N + LAT);
    idle(10);
    check_q("glitch_min");
    check_eq("glitch_min_value", {31'd0, o_value}, 0);

    // Sample gating on both edges.
    gated(1'b1, "gate_rise");
    gated(1'b0, "gate_fall");

    // Sync reset mid-count discards the partial count.
    e0    = ecnt;
    i_raw = 1'b1;
    idle(LAT + 2);
    i_sync_reset = 1'b1;
    idle(1);
    i_sync_reset = 1'b0;
    check_eq("srst_mid_value", {31'd0, o_value}, 0);
    push_exp(1'b1, e0 + LAT + N + 3);
    idle(N + 6);
    check_q("srst_mid");
    check_eq("srst_mid_after", {31'd0, o_value}, 1);

    // Sync reset while high, sample disabled: no fall pulse, synchroniser keeps its level.
    i_sample_en  = 1'b0;
    i_sync_reset = 1'b1;
    idle(1);
    i_sync_reset = 1'b0;
    check_eq("srst_high_value", {31'd0, o_value}, 0);
    i_sample_en = 1'b1;
    push_exp(1'b1, ecnt + N);
    idle(N + 6);
    check_q("srst_high");
    check_eq("srst_high_after", {31'd0, o_value}, 1);

    // Toggling every sample never reaches acceptance.
    for (int k = 0; k < 12; k++) begin
      i_raw = ~i_raw;
      @(negedge clk);
      check_eq("toggle_value", {31'd0, o_value}, 1);
    end
    i_raw = 1'b1;
    idle(10);
    check_q("toggle");
    check_eq("toggle_after", {31'd0, o_value}, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_debounce_edge

// File: doc/debounce_edge.md
# debounce_edge

- Upstream conditioning stage for the d_ff test path.
- Takes a raw asynchronous level, such as a push-button or an external strobe.
- Synchronises it and rejects glitches shorter than DEBOUNCE_CYCLES samples.
- Produces a clean level for the flip-flop `i_value` input, plus single-cycle rise/fall pulses for downstream counters.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive equal samples required to accept a new level; legal range 2..65535.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): counter width; derived, not overridden.
- clk, input, 1: single clock, rising edge.
- async_reset_n, input, 1: asynchronous, active-low reset.
- i_sync_reset, input, 1: synchronous clear; takes priority over all other inputs except async_reset_n.
- i_sample_en, input, 1: sample qualifier; when 0, the FSM and counter hold.
- i_raw, input, 1: raw input level, asynchronous to clk.
- o_value, output, 1: debounced level, registered.
- o_rise, output, 1: one-cycle pulse on an accepted 0→1 change.
- o_fall, output, 1: one-cycle pulse on an accepted 1→0 change.

## Operation
- Sampled input s_in:
  - With DEBOUNCE_SYNC_EN: the second stage of a 2-FF synchroniser on i_raw.
  - Without DEBOUNCE_SYNC_EN: i_raw directly.
- FSM has four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- A sample is a clk edge with i_sample_en=1; edges with i_sample_en=0 change nothing except the synchroniser flops, which always shift.
- IDLE_LOW:
  - s_in=1 → WAIT_HIGH, cnt=1.
  - Otherwise stay.
- WAIT_HIGH:
  - s_in=0 → IDLE_LOW, cnt=0 (glitch rejected, no pulse).
  - s_in=1 and cnt==DEBOUNCE_CYCLES-1 → IDLE_HIGH, cnt=0, o_value=1, o_rise=1.
  - Otherwise cnt++.
- IDLE_HIGH and WAIT_LOW mirror IDLE_LOW and WAIT_HIGH with levels inverted; the accept transition asserts o_fall.
- o_value is 1 exactly in IDLE_HIGH and WAIT_LOW.
- o_rise/o_fall are registered and high for exactly one clk cycle, coincident with the first cycle of the new o_value.
- They are never both high.
- The pulse deasserts on the next edge even when i_sample_en=0 on that edge.
- cnt never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
- i_sync_reset=1 on an edge, regardless of i_sample_en:
  - Effect: state IDLE_LOW, cnt 0, o_value 0, o_rise 0, o_fall 0.
  - The synchroniser flops are not cleared.
- Reset mid-WAIT (either reset) discards the partial count.
- No pulse is generated by reset, even if o_value was 1.

## Timing
- Reset values (async_reset_n=0):
  - Synchroniser flops 0, state IDLE_LOW, cnt 0.
  - o_value 0, o_rise 0, o_fall 0.
- Reset assertion is asynchronous; release is treated as synchronous to clk by the system (release synchronised externally).
- Latency, with i_sample_en held 1 and i_raw stable from before edge E1:
  - With DEBOUNCE_SYNC_EN: o_value/pulse change after edge E(DEBOUNCE_CYCLES+2).
  - Without DEBOUNCE_SYNC_EN: after edge E(DEBOUNCE_CYCLES).
- Minimum accepted pulse width: DEBOUNCE_CYCLES samples; one fewer sample is always rejected.
- i_sample_en gaps stretch latency by the number of disabled edges; the count is not lost across gaps.
- Level toggling every sample never reaches acceptance; o_value remains at its prior value.

## Configuration
- DEBOUNCE_SYNC_EN defined: 2-FF synchroniser instantiated in front of the FSM, adding 2 cycles of latency.
  - Use this for truly asynchronous sources (buttons, pins).
- DEBOUNCE_SYNC_EN undefined: i_raw feeds the FSM directly.
  - For sources already synchronous to clk.
  - No metastability protection.

## Structure
- Package debounce_pkg holds:
  - typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} deb_state_t.
  - localparam SYNC_STAGES = 2.
- Sub-module sync_2ff: asynchronous active-low reset to 0, 1-bit data in/out.
  - Instantiated only under DEBOUNCE_SYNC_EN.
- Top module contains the FSM, counter and pulse registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and DEBOUNCE_SYNC_EN defined, unless noted.
- Reset: hold async_reset_n=0 for 3 cycles with i_raw=1 → o_value=0, o_rise=0, o_fall=0 throughout, no pulse at release.
- Clean rise: i_raw 0→1 held 10 cycles with i_sample_en=1 → o_value=1 and o_rise=1 for exactly one cycle, starting after the 6th edge.
- Glitch reject: i_raw high for exactly 3 samples then low → o_value stays 0, no o_rise. Repeat with 4 samples → accepted.
- Sample gating: i_raw rises with i_sample_en alternating 1/0 → acceptance after 4 enabled samples, about 8 edges past sync; o_fall check identical for the falling edge.
- Sync reset mid-count: reach WAIT_HIGH with cnt=2, pulse i_sync_reset → IDLE_LOW, o_value 0. Accept after 4 new samples; no early accept.
- Undefined DEBOUNCE_SYNC_EN: clean rise → o_value=1 after the 4th edge, 2 cycles earlier than with the synchroniser.
